dphy_delay_calib: RTL and testbench
===================================

DPHY_DELAY_CALIB -- requirements
Module: dphy_delay_calib

Interface
REQ-001 The module SHALL have parameter DATA_LANES, default 2, meaning the number of DPHY data lanes to calibrate.
REQ-002 The module SHALL have parameter SETTLE_CYCLES, default 16, meaning the byte_clk cycles ignored after each delay load.
REQ-003 The module SHALL have parameter WINDOW_CYCLES, default 1024, meaning the byte_clk cycles observed per tap.
REQ-004 The module SHALL have parameter MIN_HITS, default 4, meaning the sync hits needed for a tap to pass.
REQ-005 The module SHALL have parameter MIN_EYE, default 3, meaning the minimum passing-run length accepted as an eye.
REQ-006 Port byte_clk: input, 1 bit, clock; the reset is clk_loss_rst_d2, asynchronous, active-high; the clock is byte_clk.
REQ-007 Port clk_loss_rst_d2: input, 1 bit, asynchronous active-high reset.
REQ-008 Port start_i: input, 1 bit, single-cycle calibration request.
REQ-009 Port sync_hit_i: input, DATA_LANES bits, per-lane one-cycle pulse when the byte aligner finds the HS sync sequence.
REQ-010 Port sync_err_i: input, DATA_LANES bits, per-lane one-cycle pulse on an alignment failure.
REQ-011 Port lane_delay_o: output, DATA_LANES x 5 bits, IDELAY tap value per lane.
REQ-012 Port delay_ld_o: output, 1 bit, one-cycle load strobe for lane_delay_o.
REQ-013 Port busy_o: output, 1 bit, high while calibration runs.
REQ-014 Port done_o: output, 1 bit, one-cycle completion pulse.
REQ-015 Port fail_o: output, DATA_LANES bits, per-lane "no valid eye" flag.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, SETTLE, OBSERVE, EVAL, COMMIT and DONE.
REQ-017 In IDLE, start_i=1 SHALL clear the lane index, the tap, the run/best trackers and fail_o, set busy_o=1, and go to LOAD; start_i SHALL be ignored in every other state.
REQ-018 LOAD SHALL last 1 cycle: lane_delay_o[lane] is set to tap and delay_ld_o=1, both registered on the same edge; then go to SETTLE.
REQ-019 SETTLE SHALL last exactly SETTLE_CYCLES cycles, and sync_hit_i and sync_err_i SHALL be ignored during it.
REQ-020 OBSERVE SHALL last exactly WINDOW_CYCLES cycles.
REQ-021 During OBSERVE, the module SHALL count sync_hit_i[lane] in a counter saturating at MIN_HITS, and any sync_err_i[lane] SHALL set a sticky error flag.
REQ-022 A cycle in which both sync_hit_i[lane] and sync_err_i[lane] are high SHALL count the hit and set the error flag.
REQ-023 Inputs of non-selected lanes SHALL be ignored.
REQ-024 EVAL SHALL last 1 cycle, and a tap SHALL pass when hits >= MIN_HITS and the error flag is clear.
REQ-025 In EVAL, a passing tap SHALL increment the current run length and set the run start to tap when the previous run length was 0; a failing tap SHALL clear the run length.
REQ-026 After the update in REQ-025, if the current run length is strictly greater than best_len, best_len and best_start SHALL be updated, so that on ties the lowest-tap run wins.
REQ-027 EVAL SHALL go to LOAD with tap+1 when tap < 31, and to COMMIT when tap = 31 (no wrap).
REQ-028 In COMMIT (1 cycle), if best_len >= MIN_EYE, lane_delay_o[lane] SHALL be set to best_start + floor((best_len-1)/2) and fail_o[lane] to 0.
REQ-029 In COMMIT, if best_len < MIN_EYE, lane_delay_o[lane] SHALL be set to 0 and fail_o[lane] to 1.
REQ-030 In COMMIT, delay_ld_o SHALL be 1; then the trackers are cleared and the FSM goes to LOAD for the next lane, or to DONE after the last lane.
REQ-031 DONE SHALL last 1 cycle with done_o=1 and busy_o cleared on exit, and then return to IDLE.
REQ-032 Timing: with T = SETTLE_CYCLES + WINDOW_CYCLES + 2, done_o SHALL be high exactly DATA_LANES*(32*T+1)+1 cycles after the cycle in which start_i is sampled.
REQ-033 lane_delay_o of lanes not under calibration SHALL hold their values.
REQ-034 fail_o and lane_delay_o SHALL hold their values until the next start or reset.
REQ-035 The run length counter SHALL be 6 bits wide (0..32), and the tap and best_start registers SHALL be 5 bits wide.

Reset
REQ-036 clk_loss_rst_d2=1 SHALL force IDLE, lane_delay_o=0, delay_ld_o=0, busy_o=0, done_o=0, fail_o=0, and clear all counters.
REQ-037 The reset in REQ-036 SHALL apply immediately, including mid-sweep.
REQ-038 After a mid-sweep reset, no done_o SHALL be produced for the aborted sweep.

Verification (SETTLE_CYCLES=2, WINDOW_CYCLES=8, MIN_HITS=2, MIN_EYE=3, DATA_LANES=2, so T=12)
REQ-039 Normal sweep: lane0 passes taps 10..20 and lane1 passes taps 5..9 -> lane_delay_o = {7,15}, fail_o=00, done_o at cycle 771, and exactly 2*33 delay_ld_o pulses.
REQ-040 Tie: lane0 passes taps 4..7 and 20..23 -> lane_delay_o[0]=5.
REQ-041 Error split: lane0 hits on taps 10..20 with a sync_err_i pulse during tap 15 -> lane_delay_o[0]=12; run ending at the top: lane0 passes taps 25..31 -> lane_delay_o[0]=28.
REQ-042 No eye: lane1 never hits, or hits only during SETTLE, or passes only taps 3..4 -> lane_delay_o[1]=0, fail_o[1]=1, and done_o still pulses.
REQ-043 Reset mid-sweep and start while busy: clk_loss_rst_d2 asserted during lane0 OBSERVE -> all outputs 0 in the same cycle and no done_o; start_i pulsed while busy_o=1 -> no effect on timing or result.

Source files
------------

// File: rtl/dphy_delay_calib.sv
// rtl/dphy_delay_calib.sv - per-lane IDELAY tap sweep that centres each lane in its widest passing eye
module dphy_delay_calib #(
    parameter int DATA_LANES    = 2,
    parameter int SETTLE_CYCLES = 16,
    parameter int WINDOW_CYCLES = 1024,
    parameter int MIN_HITS      = 4,
    parameter int MIN_EYE       = 3
) (
    input  logic                    byte_clk,
    input  logic                    clk_loss_rst_d2,
    input  logic                    start_i,
    input  logic [DATA_LANES-1:0]   sync_hit_i,
    input  logic [DATA_LANES-1:0]   sync_err_i,
    output logic [DATA_LANES*5-1:0] lane_delay_o,
    output logic                    delay_ld_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [DATA_LANES-1:0]   fail_o
);
    localparam int LANE_W  = (DATA_LANES > 1) ? $clog2(DATA_LANES) : 1;
    localparam int CNT_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int HIT_W   = $clog2(MIN_HITS + 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  WINDOW_LAST = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [HIT_W-1:0]  HIT_SAT     = HIT_W'(MIN_HITS);
    localparam logic [5:0]        EYE_MIN     = 6'(MIN_EYE);
    localparam logic [LANE_W-1:0] LANE_LAST   = LANE_W'(DATA_LANES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_OBSERVE, S_EVAL, S_COMMIT, S_DONE
    } state_t;

    state_t                          r_state;
    logic [LANE_W-1:0]               r_lane;
    logic [4:0]                      r_tap;
    logic [CNT_W-1:0]                r_cnt;
    logic [HIT_W-1:0]                r_hits;
    logic                            r_err;
    logic [5:0]                      r_run;
    logic [4:0]                      r_run_start;
    logic [5:0]                      r_best_len;
    logic [4:0]                      r_best_start;
    logic [DATA_LANES-1:0][4:0]      r_delay;
    logic                            r_ld;
    logic                            r_busy;
    logic                            r_done;
    logic [DATA_LANES-1:0]           r_fail;

    logic       w_hit;
    logic       w_err;
    logic       w_pass;
    logic [5:0] w_run_nxt;
    logic [4:0] w_run_start_nxt;
    logic       w_better;
    logic [5:0] w_best_len_nxt;
    logic [4:0] w_best_start_nxt;
    logic [5:0] w_centre;
    logic       w_eye_ok;

    assign w_hit  = sync_hit_i[r_lane];
    assign w_err  = sync_err_i[r_lane];
    assign w_pass = (r_hits == HIT_SAT) && !r_err;

    // Tracker values after this tap's verdict; the last tap's verdict feeds the commit directly.
    assign w_run_nxt        = w_pass ? (r_run + 6'd1) : 6'd0;
    assign w_run_start_nxt  = (w_pass && (r_run == 6'd0)) ? r_tap : r_run_start;
    assign w_better         = w_run_nxt > r_best_len;
    assign w_best_len_nxt   = w_better ? w_run_nxt : r_best_len;
    assign w_best_start_nxt = w_better ? w_run_start_nxt : r_best_start;
    assign w_centre         = 6'(w_best_start_nxt) + ((w_best_len_nxt - 6'd1) >> 1);
    assign w_eye_ok         = w_best_len_nxt >= EYE_MIN;

    always_ff @(posedge byte_clk or posedge clk_loss_rst_d2) begin
        if (clk_loss_rst_d2) begin
            r_state      <= S_IDLE;
            r_lane       <= '0;
            r_tap        <= '0;
            r_cnt        <= '0;
            r_hits       <= '0;
            r_err        <= 1'b0;
            r_run        <= '0;
            r_run_start  <= '0;
            r_best_len   <= '0;
            r_best_start <= '0;
            r_delay      <= '0;
            r_ld         <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= '0;
        end else begin
            r_ld   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_lane       <= '0;
                        r_tap        <= '0;
                        r_run        <= '0;
                        r_run_start  <= '0;
                        r_best_len   <= '0;
                        r_best_start <= '0;
                        r_fail       <= '0;
                        r_busy       <= 1'b1;
                        r_delay[0]   <= 5'd0;
                        r_ld         <= 1'b1;
                        r_state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_cnt   <= '0;
                    r_hits  <= '0;
                    r_err   <= 1'b0;
                    r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_OBSERVE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_OBSERVE: begin
                    if (w_hit && (r_hits != HIT_SAT)) r_hits <= r_hits + 1'b1;
                    if (w_err) r_err <= 1'b1;
                    if (r_cnt == WINDOW_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_EVAL;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_EVAL: begin
                    r_run        <= w_run_nxt;
                    r_run_start  <= w_run_start_nxt;
                    r_best_len   <= w_best_len_nxt;
                    r_best_start <= w_best_start_nxt;
                    r_ld         <= 1'b1;
                    if (r_tap == 5'd31) begin
                        r_delay[r_lane] <= w_eye_ok ? w_centre[4:0] : 5'd0;
                        r_fail[r_lane]  <= !w_eye_ok;
                        r_state         <= S_COMMIT;
                    end else begin
                        r_tap           <= r_tap + 5'd1;
                        r_delay[r_lane] <= r_tap + 5'd1;
                        r_state         <= S_LOAD;
                    end
                end
                S_COMMIT: begin
                    r_tap        <= '0;
                    r_run        <= '0;
                    r_run_start  <= '0;
                    r_best_len   <= '0;
                    r_best_start <= '0;
                    if (r_lane == LANE_LAST) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_lane                 <= r_lane + 1'b1;
                        r_delay[r_lane + 1'b1] <= 5'd0;
                        r_ld                   <= 1'b1;
                        r_state                <= S_LOAD;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign lane_delay_o = r_delay;
    assign delay_ld_o   = r_ld;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign fail_o       = r_fail;
endmodule

// File: tb/tb_dphy_delay_calib.sv
// tb/tb_dphy_delay_calib.sv - randomized sweep stimulus checked against an eye-search reference model
module tb_dphy_delay_calib;
    localparam int NL     = 2;
    localparam int S      = 2;
    localparam int W      = 8;
    localparam int MH     = 2;
    localparam int ME     = 3;
    localparam int T      = S + W + 2;
    localparam int P      = 32 * T + 1;
    localparam int DONE_K = NL * P + 1;

    logic            byte_clk;
    logic            clk_loss_rst_d2;
    logic            start_i;
    logic [NL-1:0]   sync_hit_i;
    logic [NL-1:0]   sync_err_i;
    logic [NL*5-1:0] lane_delay_o;
    logic            delay_ld_o;
    logic            busy_o;
    logic            done_o;
    logic [NL-1:0]   fail_o;

    int n_vec = 0;
    int n_bad = 0;

    logic [W-1:0] obs_hit [NL][32];
    logic [W-1:0] obs_err [NL][32];
    logic [4:0]   m_delay [NL];
    logic [NL-1:0] m_fail;

    dphy_delay_calib #(
        .DATA_LANES(NL), .SETTLE_CYCLES(S), .WINDOW_CYCLES(W),
        .MIN_HITS(MH), .MIN_EYE(ME)
    ) dut (
        .byte_clk(byte_clk), .clk_loss_rst_d2(clk_loss_rst_d2), .start_i(start_i),
        .sync_hit_i(sync_hit_i), .sync_err_i(sync_err_i), .lane_delay_o(lane_delay_o),
        .delay_ld_o(delay_ld_o), .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o)
    );

    initial byte_clk = 1'b0;
    always #5 byte_clk = ~byte_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] span(input int lo, input int hi);
        logic [31:0] m = '0;
        for (int t = lo; t <= hi; t++) m[t] = 1'b1;
        return m;
    endfunction

    // Pass taps get >=MH hits and no error; others get too few hits or an error pulse.
    task automatic fill_lane(input int l, input logic [31:0] pass_m, input logic [31:0] err_m);
        logic [W-1:0] h;
        int a;
        for (int t = 0; t < 32; t++) begin
            a = $urandom_range(W - 1);
            h = W'($urandom);
            if (pass_m[t] || err_m[t]) begin
                h[a] = 1'b1;
                h[(a + 1 + $urandom_range(W - 2)) % W] = 1'b1;
                obs_err[l][t] = err_m[t] ? (W'(1) << $urandom_range(W - 1)) : '0;
            end else if ($urandom_range(2) == 0) begin
                h = '0;
                h[a] = 1'($urandom_range(1));
                obs_err[l][t] = '0;
            end else begin
                obs_err[l][t] = W'(1) << $urandom_range(W - 1);
            end
            obs_hit[l][t] = h;
        end
    endtask

    task automatic fill_quiet(input int l);
        for (int t = 0; t < 32; t++) begin
            obs_hit[l][t] = '0;
            obs_err[l][t] = '0;
        end
    endtask

    function automatic logic [31:0] pass_mask(input int l);
        logic [31:0] m;
        for (int t = 0; t < 32; t++)
            m[t] = ($countones(obs_hit[l][t]) >= MH) && (obs_err[l][t] == '0);
        return m;
    endfunction

    // Widest run of passing taps (lowest wins on ties), centred toward its low edge.
    function automatic void eye_model(input logic [31:0] m, output logic [4:0] d, output logic f);
        logic [32:0] mm;
        int bl, bs, len;
        mm = {m, 1'b0};
        bl = 0;
        bs = 0;
        for (int s = 0; s < 32; s++) begin
            if (mm[s+1] && !mm[s]) begin
                len = 0;
                while (s + len < 32 && m[s+len]) len++;
                if (len > bl) begin
                    bl = len;
                    bs = s;
                end
            end
        end
        f = (bl < ME);
        d = f ? 5'd0 : 5'(bs + (bl - 1) / 2);
    endfunction

    function automatic logic [NL*5-1:0] model_vec();
        logic [NL*5-1:0] v;
        for (int l = 0; l < NL; l++) v[l*5 +: 5] = m_delay[l];
        return v;
    endfunction

    task automatic run_sweep(input string name, input int abort_k, input int extra_k);
        logic [4:0] exp_d [NL];
        logic       exp_f [NL];
        int lane, r, tap, off, ld_count;
        logic is_load, is_commit;
        for (int l = 0; l < NL; l++) eye_model(pass_mask(l), exp_d[l], exp_f[l]);
        ld_count = 0;
        @(negedge byte_clk);
        start_i    = 1'b1;
        sync_hit_i = NL'($urandom);
        sync_err_i = NL'($urandom);
        for (int k = 1; k <= DONE_K + 1; k++) begin
            @(negedge byte_clk);
            lane      = (k - 1) / P;
            r         = (k - 1) % P;
            tap       = r / T;
            off       = r % T;
            is_load   = (k <= NL * P) && (r < 32 * T) && (off == 0);
            is_commit = (k <= NL * P) && (r == 32 * T);
            if (k == 1) m_fail = '0;
            if (is_load) m_delay[lane] = 5'(tap);
            if (is_commit) begin
                m_delay[lane] = exp_d[lane];
                m_fail[lane]  = exp_f[lane];
            end
            if (delay_ld_o) ld_count++;
            chk($sformatf("%s k=%0d delay_ld", name, k), 32'(delay_ld_o), 32'(is_load || is_commit));
            chk($sformatf("%s k=%0d done", name, k), 32'(done_o), 32'(k == DONE_K));
            chk($sformatf("%s k=%0d busy", name, k), 32'(busy_o), 32'(k <= DONE_K));
            chk($sformatf("%s k=%0d lane_delay", name, k), 32'(lane_delay_o), 32'(model_vec()));
            chk($sformatf("%s k=%0d fail", name, k), 32'(fail_o), 32'(m_fail));

            start_i    = (k == extra_k);
            sync_hit_i = NL'($urandom);
            sync_err_i = NL'($urandom);
            if (k <= NL * P) begin
                if (r < 32 * T && off > S && off <= S + W) begin
                    sync_hit_i[lane] = obs_hit[lane][tap][off-S-1];
                    sync_err_i[lane] = obs_err[lane][tap][off-S-1];
                end else if (!(r < 32 * T && off >= 1 && off <= S)) begin
                    sync_hit_i[lane] = 1'b0;
                    sync_err_i[lane] = 1'b0;
                end
            end

            if (k == abort_k) begin
                #2 clk_loss_rst_d2 = 1'b1;
                #1;
                chk({name, " rst lane_delay"}, 32'(lane_delay_o), 32'd0);
                chk({name, " rst delay_ld"}, 32'(delay_ld_o), 32'd0);
                chk({name, " rst busy"}, 32'(busy_o), 32'd0);
                chk({name, " rst done"}, 32'(done_o), 32'd0);
                chk({name, " rst fail"}, 32'(fail_o), 32'd0);
                for (int l = 0; l < NL; l++) m_delay[l] = 5'd0;
                m_fail  = '0;
                start_i = 1'b0;
                @(negedge byte_clk);
                clk_loss_rst_d2 = 1'b0;
                for (int j = 0; j < DONE_K + 5; j++) begin
                    @(negedge byte_clk);
                    chk($sformatf("%s post-rst j=%0d done", name, j), 32'(done_o), 32'd0);
                    chk($sformatf("%s post-rst j=%0d busy", name, j), 32'(busy_o), 32'd0);
                    sync_hit_i = NL'($urandom);
                    sync_err_i = NL'($urandom);
                end
                return;
            end
        end
        chk({name, " delay_ld count"}, 32'(ld_count), 32'(NL * 33));
    endtask

    initial begin
        logic [31:0] rm;
        int lo;
        clk_loss_rst_d2 = 1'b1;
        start_i         = 1'b0;
        sync_hit_i      = '0;
        sync_err_i      = '0;
        for (int l = 0; l < NL; l++) m_delay[l] = 5'd0;
        m_fail = '0;
        repeat (3) @(negedge byte_clk);
        chk("reset lane_delay", 32'(lane_delay_o), 32'd0);
        chk("reset delay_ld", 32'(delay_ld_o), 32'd0);
        chk("reset busy", 32'(busy_o), 32'd0);
        chk("reset done", 32'(done_o), 32'd0);
        chk("reset fail", 32'(fail_o), 32'd0);
        clk_loss_rst_d2 = 1'b0;

        fill_lane(0, span(10, 20), '0);
        fill_lane(1, span(5, 9), '0);
        run_sweep("normal", 0, 0);
        chk("normal result", 32'(lane_delay_o), 32'({5'd7, 5'd15}));
        chk("normal fail", 32'(fail_o), 32'd0);

        fill_lane(0, span(4, 7) | span(20, 23), '0);
        fill_quiet(1);
        run_sweep("tie", 0, 100);
        chk("tie lane0", 32'(lane_delay_o[4:0]), 32'd5);
        chk("quiet lane1 fail", 32'(fail_o[1]), 32'd1);

        fill_lane(0, span(10, 14) | span(16, 20), span(15, 15));
        fill_lane(1, span(3, 4), '0);
        run_sweep("errsplit", 0, DONE_K);
        chk("errsplit lane0", 32'(lane_delay_o[4:0]), 32'd12);
        chk("short lane1", 32'(lane_delay_o[9:5]), 32'd0);
        chk("short lane1 fail", 32'(fail_o[1]), 32'd1);
        chk("short done seen", 32'(fail_o[0]), 32'd0);

        fill_lane(0, span(25, 31), '0);
        fill_lane(1, $urandom & $urandom, '0);
        run_sweep("top", 0, 0);
        chk("top lane0", 32'(lane_delay_o[4:0]), 32'd28);

        fill_lane(0, span(10, 20), '0);
        fill_lane(1, span(5, 9), '0);
        run_sweep("abort", 1 + 3 * T + S + 4, 0);

        for (int i = 0; i < 3; i++) begin
            for (int l = 0; l < NL; l++) begin
                lo = $urandom_range(31);
                rm = ($urandom & $urandom & $urandom) | span(lo, (lo + 8 > 31) ? 31 : lo + $urandom_range(8));
                fill_lane(l, rm, $urandom & $urandom & ~rm);
            end
            run_sweep($sformatf("rand%0d", i), 0, $urandom_range(1, DONE_K));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
